fft_output_reorder: RTL and testbench

//  Sink for the in-place FFT result stream. Collects the two-lane final-stage

---
 rtl/fft_output_reorder.sv | 165 ++++++++++++++++
 tb/tb_fft_output_reorder.sv | 300 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fft_output_reorder.sv
// Collects bit-reversed two-lane FFT result pairs into a two-bank buffer and
// streams them out one bin per cycle in natural order over valid/ready.
module fft_output_reorder #(
    parameter int BW     = 16,
    parameter int N_LOG2 = 6
) (
    input  logic              clk,
    input  logic              nrst,
    input  logic              start,
    input  logic              in_valid,
    input  logic [BW-1:0]     inReal0,
    input  logic [BW-1:0]     inImag0,
    input  logic [BW-1:0]     inReal1,
    input  logic [BW-1:0]     inImag1,
    output logic              in_ready,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [BW-1:0]     outReal,
    output logic [BW-1:0]     outImag,
    output logic [N_LOG2-1:0] out_bin,
    output logic              out_last,
    output logic              overrun
);
    localparam int N    = 1 << N_LOG2;
    localparam int HALF = N / 2;
    localparam int AW   = N_LOG2 - 1;

    typedef enum logic [1:0] { IDLE, COLLECT, DRAIN } state_t;

    state_t            state_q, state_d;
    logic [AW-1:0]     k_q, k_d;
    logic [N_LOG2-1:0] rd_ptr_q, rd_ptr_d;
    logic              out_valid_q, out_valid_d;
    logic              out_last_q, out_last_d;
    logic [N_LOG2-1:0] out_bin_q, out_bin_d;
    logic [BW-1:0]     out_real_q, out_real_d;
    logic [BW-1:0]     out_imag_q, out_imag_d;
    logic              overrun_q, overrun_d;

    logic              wr_en;
    logic [AW-1:0]     wr_k;
    logic [AW-1:0]     wr_addr;
    logic              load;

    logic [2*BW-1:0]   bank0 [HALF];
    logic [2*BW-1:0]   bank1 [HALF];

    function automatic logic [AW-1:0] bitrev_aw(input logic [AW-1:0] v);
        logic [AW-1:0] r;
        for (int i = 0; i < AW; i++) r[i] = v[AW-1-i];
        return r;
    endfunction

    // Reversing {k,0} over N_LOG2 bits gives {0, reverse(k)}: the zero MSB keeps
    // lane 0 in the lower half, so only the AW-bit reversal is needed as address.
    assign wr_addr = bitrev_aw(wr_k);

    always_comb begin
        // NOTE: every signal gets a default before the case so no path leaves
        // one unassigned, which would otherwise infer a latch.
        state_d     = state_q;
        k_d         = k_q;
        rd_ptr_d    = rd_ptr_q;
        out_valid_d = out_valid_q;
        out_last_d  = out_last_q;
        out_bin_d   = out_bin_q;
        out_real_d  = out_real_q;
        out_imag_d  = out_imag_q;
        overrun_d   = 1'b0;
        wr_en       = 1'b0;
        wr_k        = '0;
        load        = 1'b0;

        unique case (state_q)
            IDLE: begin
                if (start) begin
                    state_d = COLLECT;
                    k_d     = '0;
                    if (in_valid) begin
                        wr_en = 1'b1;
                        k_d   = AW'(1);
                    end
                end else if (in_valid) begin
                    overrun_d = 1'b1;
                end
            end
            COLLECT: begin
                if (start) k_d = '0;
                if (in_valid) begin
                    wr_en = 1'b1;
                    wr_k  = start ? '0 : k_q;
                    k_d   = wr_k + AW'(1);
                    if (wr_k == AW'(HALF - 1)) begin
                        state_d  = DRAIN;
                        rd_ptr_d = '0;
                    end
                end
            end
            DRAIN: begin
                overrun_d = in_valid;
                // Refill the output register when it is empty or being consumed,
                // unless the sample being consumed is the last one.
                load = !out_valid_q || (out_ready && !out_last_q);
                if (out_valid_q && out_ready && out_last_q) begin
                    out_valid_d = 1'b0;
                    out_last_d  = 1'b0;
                    state_d     = IDLE;
                end
                if (load) begin
                    out_valid_d = 1'b1;
                    out_bin_d   = rd_ptr_q;
                    out_last_d  = (rd_ptr_q == N_LOG2'(N - 1));
                    {out_real_d, out_imag_d} = rd_ptr_q[AW] ? bank1[rd_ptr_q[AW-1:0]]
                                                            : bank0[rd_ptr_q[AW-1:0]];
                    rd_ptr_d    = rd_ptr_q + N_LOG2'(1);
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        // NOTE: state uses non-blocking assignments so every flop samples the
        // pre-edge values, independent of statement order.
        if (!nrst) begin
            state_q     <= IDLE;
            k_q         <= '0;
            rd_ptr_q    <= '0;
            out_valid_q <= 1'b0;
            out_last_q  <= 1'b0;
            out_bin_q   <= '0;
            out_real_q  <= '0;
            out_imag_q  <= '0;
            overrun_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            k_q         <= k_d;
            rd_ptr_q    <= rd_ptr_d;
            out_valid_q <= out_valid_d;
            out_last_q  <= out_last_d;
            out_bin_q   <= out_bin_d;
            out_real_q  <= out_real_d;
            out_imag_q  <= out_imag_d;
            overrun_q   <= overrun_d;
        end
    end

    // NOTE: the sample buffer is deliberately not reset; every word is rewritten
    // before it is read, and leaving it out lets the tools map it to RAM.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            bank0[wr_addr] <= {inReal0, inImag0};
            bank1[wr_addr] <= {inReal1, inImag1};
        end
    end

    assign in_ready  = (state_q == COLLECT);
    assign out_valid = out_valid_q;
    assign out_last  = out_last_q;
    assign out_bin   = out_bin_q;
    assign outReal   = out_real_q;
    assign outImag   = out_imag_q;
    assign overrun   = overrun_q;

endmodule

// File: tb/tb_fft_output_reorder.sv
// Self-checking bench for fft_output_reorder (N_LOG2=3, BW=16): table vectors,
// hand-written corner sequences and randomized frames against a bin-map model.
module tb_fft_output_reorder;
    localparam int BW = 16;
    localparam int NL = 3;
    localparam int N  = 1 << NL;
    localparam int H  = N / 2;

    logic          clk = 1'b0;
    logic          nrst, start, in_valid, out_ready;
    logic [BW-1:0] inReal0, inImag0, inReal1, inImag1;
    logic          in_ready, out_valid, out_last, overrun;
    logic [BW-1:0] outReal, outImag;
    logic [NL-1:0] out_bin;

    always #5 clk = ~clk;

    fft_output_reorder #(.BW(BW), .N_LOG2(NL)) dut (
        .clk(clk), .nrst(nrst), .start(start), .in_valid(in_valid),
        .inReal0(inReal0), .inImag0(inImag0), .inReal1(inReal1), .inImag1(inImag1),
        .in_ready(in_ready), .out_valid(out_valid), .out_ready(out_ready),
        .outReal(outReal), .outImag(outImag), .out_bin(out_bin),
        .out_last(out_last), .overrun(overrun)
    );

    typedef struct {
        logic [BW-1:0] re;
        logic [BW-1:0] im;
        logic          last;
    } vec_t;

    int            n_checks = 0;
    int            n_fail   = 0;
    logic [BW-1:0] exp_re [N];
    logic [BW-1:0] exp_im [N];
    int            model_k;
    logic [BW-1:0] got_re [N];
    logic [BW-1:0] got_im [N];
    logic          got_last [N];
    vec_t          t1 [N];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h) at %0t",
                     name, act, act, exp, exp, $time);
        end
    endtask

    // Model: pair k lands in bins bitrev(2k) and bitrev(2k)+N/2.
    function automatic int bitrev(input int v);
        int r = 0;
        for (int i = 0; i < NL; i++) r = r * 2 + ((v >> i) & 1);
        return r;
    endfunction

    task automatic model_pair(input logic [BW-1:0] re0, im0, re1, im1);
        int b = bitrev(2 * model_k);
        exp_re[b]     = re0;
        exp_im[b]     = im0;
        exp_re[b + H] = re1;
        exp_im[b + H] = im1;
        model_k++;
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic set_data(input logic [BW-1:0] re0, im0, re1, im1);
        inReal0 = re0; inImag0 = im0; inReal1 = re1; inImag1 = im1;
    endtask

    task automatic begin_frame(input bit with_pair, input logic [BW-1:0] re0, im0, re1, im1);
        start    = 1'b1;
        in_valid = with_pair;
        set_data(re0, im0, re1, im1);
        model_k  = 0;
        if (with_pair) model_pair(re0, im0, re1, im1);
        tick;
        start    = 1'b0;
        in_valid = 1'b0;
    endtask

    task automatic send_pair(input logic [BW-1:0] re0, im0, re1, im1);
        check("in_ready_collect", in_ready, 1);
        in_valid = 1'b1;
        set_data(re0, im0, re1, im1);
        model_pair(re0, im0, re1, im1);
        tick;
        in_valid = 1'b0;
    endtask

    task automatic send_std(input int k);
        send_pair(BW'(16 * k), BW'(-16 * k), BW'(16 * k + 1), BW'(-(16 * k + 1)));
    endtask

    // ready_mode: 0 always ready, 1 pattern 1,0,0,1, 2 random.
    task automatic drain(input int ready_mode, input bit inject, input int stop_bin,
                         input bit chk_latency);
        int            idx = 0;
        int            cyc = 0;
        int            gaps = 0;
        bit            seen = 0;
        bit            held = 0;
        bit            prev_iv = 0;
        logic [BW-1:0] h_re, h_im;
        logic [NL-1:0] h_bin;
        while (idx < N && cyc < 200) begin
            if (chk_latency && cyc == 0) check("drain_entry_valid", out_valid, 0);
            if (chk_latency && cyc == 1) check("drain_first_valid", out_valid, 1);
            if (inject) check("overrun_drain", overrun, prev_iv);
            check("in_ready_drain", in_ready, 0);
            if (held) begin
                check("hold_valid", out_valid, 1);
                check("hold_bin", out_bin, h_bin);
                check("hold_re", outReal, h_re);
                check("hold_im", outImag, h_im);
            end
            if (stop_bin >= 0 && out_valid && int'(out_bin) == stop_bin) break;
            case (ready_mode)
                0:       out_ready = 1'b1;
                1:       out_ready = (cyc % 4 == 0) || (cyc % 4 == 3);
                default: out_ready = 1'($urandom_range(0, 1));
            endcase
            if (out_valid) begin
                seen = 1;
                if (out_ready) begin
                    check("out_bin", out_bin, idx);
                    check("out_re", outReal, exp_re[idx]);
                    check("out_im", outImag, exp_im[idx]);
                    check("out_last", out_last, idx == N - 1);
                    got_re[idx]   = outReal;
                    got_im[idx]   = outImag;
                    got_last[idx] = out_last;
                    idx++;
                    held = 0;
                end else begin
                    held  = 1;
                    h_re  = outReal;
                    h_im  = outImag;
                    h_bin = out_bin;
                end
            end else begin
                held = 0;
                if (seen) gaps++;
            end
            if (inject) begin
                in_valid = 1'($urandom_range(0, 1));
                start    = ($urandom_range(0, 3) == 0);
                set_data(BW'($urandom), BW'($urandom), BW'($urandom), BW'($urandom));
                prev_iv  = in_valid;
            end
            tick;
            cyc++;
        end
        start = 1'b0;
        if (stop_bin < 0) begin
            if (inject) check("overrun_drain_end", overrun, prev_iv);
            check("drain_count", idx, N);
            check("valid_after_last", out_valid, 0);
            check("last_after_last", out_last, 0);
            check("in_ready_idle", in_ready, 0);
            if (ready_mode == 0) check("drain_gaps", gaps, 0);
        end
        in_valid = 1'b0;
    endtask

    task automatic do_reset;
        nrst      = 1'b0;
        start     = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        set_data('0, '0, '0, '0);
        tick;
        tick;
        nrst = 1'b1;
    endtask

    task automatic check_reset_state(input string tag);
        check({tag, "_in_ready"}, in_ready, 0);
        check({tag, "_out_valid"}, out_valid, 0);
        check({tag, "_out_last"}, out_last, 0);
        check({tag, "_overrun"}, overrun, 0);
        check({tag, "_out_re"}, outReal, 0);
        check({tag, "_out_im"}, outImag, 0);
        check({tag, "_out_bin"}, out_bin, 0);
    endtask

    task automatic std_frame;
        begin_frame(0, '0, '0, '0, '0);
        for (int k = 0; k < H; k++) send_std(k);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        int re_tab [N] = '{0, 32, 16, 48, 1, 33, 17, 49};
        for (int b = 0; b < N; b++) begin
            t1[b].re   = BW'(re_tab[b]);
            t1[b].im   = BW'(-re_tab[b]);
            t1[b].last = (b == N - 1);
        end

        do_reset;
        check_reset_state("reset");

        // Basic frame, always ready, compared against the fixed table.
        std_frame;
        drain(0, 0, -1, 1);
        for (int b = 0; b < N; b++) begin
            check("t1_re", got_re[b], t1[b].re);
            check("t1_im", got_im[b], t1[b].im);
            check("t1_last", got_last[b], t1[b].last);
        end

        // Same frame with backpressure pattern.
        std_frame;
        drain(1, 0, -1, 0);
        for (int b = 0; b < N; b++) begin
            check("t2_re", got_re[b], t1[b].re);
            check("t2_im", got_im[b], t1[b].im);
        end

        // Restart inside COLLECT discards the partial frame.
        begin_frame(0, '0, '0, '0, '0);
        send_std(0);
        send_std(1);
        begin_frame(0, '0, '0, '0, '0);
        for (int k = 0; k < H; k++)
            send_pair(BW'(100 + k), BW'(-(100 + k)), BW'(300 + k), BW'(-(300 + k)));
        drain(0, 0, -1, 0);
        check("restart_bin0_re", got_re[0], 100);
        check("restart_bin2_re", got_re[2], 101);

        // Overrun in IDLE, then injected traffic during DRAIN.
        in_valid = 1'b1;
        set_data(16'h1234, 16'h5678, 16'h9abc, 16'hdef0);
        tick;
        check("overrun_idle_1", overrun, 1);
        check("in_ready_idle_ovr", in_ready, 0);
        check("out_valid_idle_ovr", out_valid, 0);
        tick;
        check("overrun_idle_2", overrun, 1);
        in_valid = 1'b0;
        tick;
        check("overrun_idle_clear", overrun, 0);
        std_frame;
        drain(0, 1, -1, 0);

        // Reset while bin 3 is presented, then a fresh frame.
        std_frame;
        drain(0, 0, 3, 0);
        check("pre_reset_bin", out_bin, 3);
        nrst = 1'b0;
        tick;
        check_reset_state("mid_drain_reset");
        nrst = 1'b1;
        begin_frame(0, '0, '0, '0, '0);
        for (int k = 0; k < H; k++)
            send_pair(BW'($urandom), BW'($urandom), BW'($urandom), BW'($urandom));
        drain(0, 0, -1, 1);

        // Start coincident with the first pair, pairs back-to-back.
        begin_frame(1, 16'd0, 16'd0, 16'd1, 16'hffff);
        check("coincident_in_ready", in_ready, 1);
        for (int k = 1; k < H; k++) send_std(k);
        drain(0, 0, -1, 1);
        for (int b = 0; b < N; b++) check("t6_re", got_re[b], t1[b].re);

        // Randomized frames: idle gaps, optional restart, random backpressure.
        for (int f = 0; f < 8; f++) begin
            bit restarted = 0;
            bit wp = 1'($urandom_range(0, 1));
            begin_frame(wp, BW'($urandom), BW'($urandom), BW'($urandom), BW'($urandom));
            while (model_k < H) begin
                if ($urandom_range(0, 3) == 0) begin
                    check("in_ready_gap", in_ready, 1);
                    tick;
                end else if (!restarted && model_k > 0 && $urandom_range(0, 5) == 0) begin
                    restarted = 1;
                    begin_frame(1'($urandom_range(0, 1)), BW'($urandom), BW'($urandom),
                                BW'($urandom), BW'($urandom));
                end else begin
                    send_pair(BW'($urandom), BW'($urandom), BW'($urandom), BW'($urandom));
                end
            end
            drain(2, 1, -1, 0);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
